// File: rtl/mem_pkg.sv
// Shared types for the CPU memory responder: access sizes, FSM states and the
// alignment rule applied at request capture.
package mem_pkg;

    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD} mem_size_t;
    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP} resp_state_t;

    localparam int WORD_W = 32;

    // Reserved size counts as a bad access alongside real misalignment.
    function automatic logic bad_align(input mem_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_WORD: return lo != 2'b00;
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian store merge: replaces the addressed byte/halfword lanes of the
// old word with right-justified store data.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] Datain,
    input  mem_size_t         Size,
    input  logic [1:0]        Address,
    output logic [WORD_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        case (Size)
            SZ_WORD: merged = Datain;
            SZ_HALF: begin
                if (Address[1]) merged[31:16] = Datain[15:0];
                else            merged[15:0]  = Datain[15:0];
            end
            SZ_BYTE: begin
                case (Address)
                    2'd0:    merged[7:0]   = Datain[7:0];
                    2'd1:    merged[15:8]  = Datain[7:0];
                    2'd2:    merged[23:16] = Datain[7:0];
                    default: merged[31:24] = Datain[7:0];
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Target side of the CPU memory port: one request at a time, served from an
// internal word array with wait states and hardware read-modify-write for sb/sh.
module cpu_mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [1:0]        Size,
    input  logic [31:0]       Address,
    input  logic [WORD_W-1:0] Datain,
    output logic [WORD_W-1:0] Dataout,
    output logic              Ready,
    output logic              Err,
    output logic              Busy
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
    localparam bit          HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0]  WLAST    = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    generate
        if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait
            $error("cpu_mem_responder: WAIT_STATES must be 0..15");
        end
    endgenerate

    logic [WORD_W-1:0] r_mem [DEPTH];

    resp_state_t       r_state, w_next;
    logic              r_wr, r_err;
    mem_size_t         r_size;
    logic [AW-1:0]     r_idx;
    logic [1:0]        r_lane;
    logic [WORD_W-1:0] r_din, r_dout, r_rdata;
    logic [3:0]        r_wcnt;

    mem_size_t         w_size;
    logic              w_cap, w_err, w_sub, w_wait_done, w_we, w_load;
    logic [AW-1:0]     w_cap_idx, w_raddr, w_waddr;
    logic [WORD_W-1:0] w_wdata, w_merged;

    assign w_size      = mem_size_t'(Size);
    assign w_cap       = reset && (r_state == IDLE) && Req;
    assign w_err       = bad_align(w_size, Address[1:0]) || ({1'b0, Address} >= LIMIT);
    assign w_sub       = Wr && (w_size == SZ_HALF || w_size == SZ_BYTE);
    assign w_wait_done = (r_wcnt == WLAST);
    assign w_cap_idx   = Address[AW+1:2];
    assign w_raddr     = (r_state == IDLE) ? w_cap_idx : r_idx;
    assign w_load      = !r_wr && !r_err;
    assign Err         = r_err;

    byte_lane_merge u_merge (
        .old_word (r_rdata),
        .Datain   (r_din),
        .Size     (r_size),
        .Address  (r_lane),
        .merged   (w_merged)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The capture edge already issues the array read, so RMW_RD only covers
    // the extra wait states and is skipped when there are none.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cap) begin
                    if (w_err)      w_next = RESP;
                    else if (w_sub) w_next = HAS_WAIT ? RMW_RD : RMW_WR;
                    else            w_next = HAS_WAIT ? RD_WAIT : RESP;
                end
            end
            RD_WAIT: if (w_wait_done) w_next = RESP;
            RMW_RD:  if (w_wait_done) w_next = RMW_WR;
            RMW_WR:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        Ready   = (r_state == RESP);
        Busy    = (r_state != IDLE);
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wdata = r_din;
        case (r_state)
            IDLE: begin
                if (w_cap && !w_err && Wr && w_size == SZ_WORD && !HAS_WAIT) begin
                    w_we    = 1'b1;
                    w_waddr = w_cap_idx;
                    w_wdata = Datain;
                end
            end
            RD_WAIT: w_we = r_wr && w_wait_done;
            RMW_WR: begin
                w_we    = 1'b1;
                w_wdata = w_merged;
            end
            default: ;
        endcase
        Dataout = (r_state == RESP && w_load) ? r_rdata : r_dout;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_size <= SZ_WORD;
            r_idx  <= '0;
            r_lane <= 2'b00;
            r_din  <= '0;
            r_dout <= '0;
            r_wcnt <= 4'd0;
        end else begin
            if (w_cap) begin
                r_wr   <= Wr;
                r_err  <= w_err;
                r_size <= w_size;
                r_idx  <= w_cap_idx;
                r_lane <= Address[1:0];
                r_din  <= Datain;
                r_dout <= '0;
            end
            if (w_we) r_dout <= w_wdata;
            if (r_state == RESP && w_load) r_dout <= r_rdata;
            if ((r_state == RD_WAIT || r_state == RMW_RD) && !w_wait_done)
                r_wcnt <= (r_wcnt == 4'hF) ? r_wcnt : r_wcnt + 4'd1;
            else
                r_wcnt <= 4'd0;
        end
    end

    // Array contents survive reset; write enable is only ever raised outside reset.
    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[w_raddr];
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Random + directed bench for cpu_mem_responder; two instances (0 and 3 wait
// states) see the same request stream and are checked against one array model.
module tb_cpu_mem_responder;

    localparam int DEPTH = 64;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        Req = 1'b0, Wr = 1'b0;
    logic [1:0]  Size = 2'd0;
    logic [31:0] Address = '0, Datain = '0;
    logic [31:0] dout [2];
    logic        rdy [2], err [2], busy [2];

    always #5 clock = ~clock;

    cpu_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_ws0 (
        .clock(clock), .reset(reset), .Req(Req), .Wr(Wr), .Size(Size),
        .Address(Address), .Datain(Datain), .Dataout(dout[0]), .Ready(rdy[0]),
        .Err(err[0]), .Busy(busy[0]));

    cpu_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_ws3 (
        .clock(clock), .reset(reset), .Req(Req), .Wr(Wr), .Size(Size),
        .Address(Address), .Datain(Datain), .Dataout(dout[1]), .Ready(rdy[1]),
        .Err(err[1]), .Busy(busy[1]));

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    bit          act = 1'b0;
    time         tcap = 0;
    int          lat [2];
    logic [31:0] exp_d = '0;
    logic        exp_e = 1'b0;
    bit          exp_dk = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle compare of both instances against the current expectation.
    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (!reset || !act) begin
                    chk($sformatf("idle_ready[%0d]", i), 32'(rdy[i]), 32'd0);
                    chk($sformatf("idle_busy[%0d]", i), 32'(busy[i]), 32'd0);
                    chk($sformatf("idle_err[%0d]", i), 32'(err[i]), 32'd0);
                    chk($sformatf("idle_dout[%0d]", i), dout[i], 32'd0);
                end else begin
                    int k;
                    k = int'(($time - tcap + 5) / 10);
                    if (k < lat[i]) begin
                        chk($sformatf("wait_ready[%0d]", i), 32'(rdy[i]), 32'd0);
                        chk($sformatf("wait_busy[%0d]", i), 32'(busy[i]), 32'd1);
                    end else begin
                        chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(k == lat[i]));
                        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(k == lat[i]));
                        chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(exp_e));
                        if (exp_dk) chk($sformatf("dout[%0d]", i), dout[i], exp_d);
                    end
                end
            end
        end
    end

    function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd0 && a[1:0] != 2'd0) ||
               (sz == 2'd1 && a[0]) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit noise,
                       output logic [31:0] got, output int l0, output int l1);
        bit          e, known;
        int          idx, sh;
        logic [31:0] word, mask;
        @(negedge clock);
        Wr = wr; Size = sz; Address = a; Datain = d; Req = 1'b1;
        e = m_err(sz, a);
        idx = int'(a >> 2);
        word = '0;
        known = 1'b1;
        if (!e) begin
            word  = mdl_mem[idx];
            known = mdl_known[idx];
            if (wr) begin
                if (sz == 2'd0) begin
                    word = d; known = 1'b1;
                end else begin
                    sh   = (sz == 2'd2) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
                    mask = ((sz == 2'd2) ? 32'hFF : 32'hFFFF) << sh;
                    word = (word & ~mask) | ((d << sh) & mask);
                end
                mdl_mem[idx]   = word;
                mdl_known[idx] = known;
            end
        end
        @(posedge clock);
        tcap = $time; act = 1'b1;
        exp_e = e; exp_d = word; exp_dk = known;
        lat[0] = e ? 1 : ((wr && sz != 2'd0) ? 2 + WS0 : 1 + WS0);
        lat[1] = e ? 1 : ((wr && sz != 2'd0) ? 2 + WS1 : 1 + WS1);
        l0 = -1; l1 = -1; got = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (noise && k <= lat[0]) begin
                Req = 1'b1; Wr = 1'($urandom); Size = 2'($urandom);
                Address = $urandom; Datain = $urandom;
            end else begin
                Req = 1'b0;
            end
            if (rdy[0] && l0 < 0) begin l0 = k; got = dout[0]; end
            if (rdy[1] && l1 < 0) l1 = k;
            if (l0 >= 0 && l1 >= 0) break;
        end
        if (l0 < 0 || l1 < 0) chk("ready_timeout", 32'(l0 < 0 || l1 < 0), 32'd0);
    endtask

    logic [31:0] got;
    int          l0, l1;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mdl_mem[i] = '0; mdl_known[i] = 1'b0; end
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;

        for (int i = 0; i < 16; i++) req(1'b1, 2'd0, 32'(4 * i), $urandom, 1'b0, got, l0, l1);

        // Directed: word load/store and latency pins.
        req(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 1'b0, got, l0, l1);
        req(1'b0, 2'd0, 32'h10, 32'h0, 1'b0, got, l0, l1);
        chk("t1_load_data", got, 32'hDEADBEEF);
        chk("t1_lat_ws0", 32'(l0), 32'd1);
        chk("t5_load_lat_ws3", 32'(l1), 32'd4);
        req(1'b1, 2'd0, 32'h20, 32'h12345678, 1'b0, got, l0, l1);
        chk("t2_store_lat", 32'(l0), 32'd1);
        req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, got, l0, l1);
        chk("t2_load_data", got, 32'h12345678);

        // Sub-word merges.
        req(1'b1, 2'd0, 32'h20, 32'hAABBCCDD, 1'b0, got, l0, l1);
        req(1'b1, 2'd2, 32'h22, 32'h11, 1'b0, got, l0, l1);
        chk("t3_byte_lat_ws0", 32'(l0), 32'd2);
        chk("t5_byte_lat_ws3", 32'(l1), 32'd5);
        chk("t3_byte_merged", got, 32'hAA11CCDD);
        req(1'b1, 2'd1, 32'h20, 32'h9988, 1'b0, got, l0, l1);
        req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, got, l0, l1);
        chk("t3_final_word", got, 32'hAA119988);

        // Error cases leave the array alone.
        req(1'b1, 2'd1, 32'h21, 32'hFFFF, 1'b0, got, l0, l1);
        chk("t4_half_odd_lat", 32'(l1), 32'd1);
        chk("t4_half_odd_dout", got, 32'd0);
        req(1'b1, 2'd0, 32'h22, 32'hFFFFFFFF, 1'b0, got, l0, l1);
        chk("t4_word_mis_lat", 32'(l0), 32'd1);
        req(1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, 1'b0, got, l0, l1);
        chk("t4_rsvd_lat", 32'(l1), 32'd1);
        req(1'b1, 2'd0, 32'(4 * DEPTH), 32'hFFFFFFFF, 1'b0, got, l0, l1);
        chk("t4_range_lat", 32'(l0), 32'd1);
        req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, got, l0, l1);
        chk("t4_unchanged", got, 32'hAA119988);

        // Requests pulsed while busy must be dropped.
        req(1'b0, 2'd0, 32'h10, 32'h0, 1'b1, got, l0, l1);
        chk("t5_noise_load", got, 32'hDEADBEEF);
        req(1'b1, 2'd2, 32'h13, 32'h5A, 1'b1, got, l0, l1);
        chk("t5_noise_byte", got, 32'h5AADBEEF);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
            else if (sel == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            else if (sel == 2) a = $urandom;
            else               a = 32'($urandom_range(0, 63));
            req(1'($urandom), 2'($urandom), a, $urandom, 1'($urandom), got, l0, l1);
        end

        // Reset during RMW_WR of the zero-wait instance aborts the store.
        req(1'b1, 2'd0, 32'h08, 32'h0, 1'b0, got, l0, l1);
        @(negedge clock);
        Wr = 1'b1; Size = 2'd2; Address = 32'h08; Datain = 32'hFF; Req = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0; act = 1'b0;
        #1 chk("t6_busy_cleared", 32'(busy[0]), 32'd0);
        chk("t6_dout_cleared", dout[0], 32'd0);
        @(negedge clock) Req = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        req(1'b0, 2'd0, 32'h08, 32'h0, 1'b0, got, l0, l1);
        chk("t6_no_write", got, 32'h0);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
